// File: rtl/reaction_pkg.sv
// ----------------------------------------------------------------------------
// reaction_pkg
// Shared types and constants for the multi-round reaction timer:
//   - FSM state encoding
//   - 7-segment glyph codes understood by the display muxer
//   - LFSR seed / tap mask and step function
//   - 4-digit BCD incrementer used by the live reaction counter
// ----------------------------------------------------------------------------
package reaction_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        REACT,
        SHOW,
        FAULT,
        SUMMARY
    } state_t;

    // Display codes above 9 are glyphs in the downstream muxer.
    localparam logic [3:0] GLYPH_H    = 4'd10;
    localparam logic [3:0] GLYPH_I    = 4'd11;
    localparam logic [3:0] GLYPH_DASH = 4'd12;
    localparam logic [3:0] GLYPH_E    = 4'd13;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10.
    localparam logic [15:0] LFSR_SEED = 16'h00FF;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic [13:0] BEST_NONE = 14'd16383;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], ^(l & LFSR_TAPS)};
    endfunction

    // Ripple-carry increment of four packed BCD digits (9999 wraps to 0000,
    // which never happens because the count saturates first).
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// ----------------------------------------------------------------------------
// bin2bcd_seq
// Iterative double-dabble: converts a 14-bit binary value into four packed
// BCD digits, one bit per clock (14 clocks after start_i).
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   start_i      one-cycle launch, samples bin_i
//   bin_i[13:0]  value to convert (expected <= 9999)
//   done_o       high from conversion end until the next start_i
//   bcd_o[15:0]  digits {thousands, hundreds, tens, ones}
// ----------------------------------------------------------------------------
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [13:0] bin_i,
    output logic        done_o,
    output logic [15:0] bcd_o
);

    logic [13:0] bin_q;
    logic [15:0] bcd_q;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [15:0] adj;

    // Add-3 correction for every digit that is 5 or more before the shift.
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
        assign adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start_i) begin
            bin_q  <= bin_i;
            bcd_q  <= '0;
            cnt_q  <= 4'd14;
            busy_q <= 1'b1;
            done_q <= 1'b0;
        end else if (busy_q) begin
            {bcd_q, bin_q} <= {adj[14:0], bin_q, 1'b0};
            cnt_q          <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/reaction_timer_multi.sv
// ----------------------------------------------------------------------------
// reaction_timer_multi
// Multi-round reaction timer. Each round waits a pseudo-random delay, lights
// the lamp and counts ticks until stop is pressed (or the count saturates).
// Tracks best and average reaction over ROUNDS rounds.
// Ports:
//   clock, reset        clock / asynchronous active-low reset
//   start, stop         raw button levels (synchronised internally)
//   led                 stimulus lamp
//   digit3..digit0      display codes (0-9 BCD, 10=H, 11=I, 12=dash, 13=E)
//   round_idx           current round, 0-based
//   result_valid        one-cycle pulse when a round result is latched
//   false_start         one-cycle pulse on stop before the lamp
//   best_ticks          best reaction this session (16383 = none)
//   avg_ticks           session sum >> log2(ROUNDS), updated on SUMMARY entry
// ----------------------------------------------------------------------------
module reaction_timer_multi
    import reaction_pkg::*;
#(
    parameter int CLK_HZ          = 100000000,
    parameter int TICK_HZ         = 1000,
    parameter int MIN_DELAY_TICKS = 1000,
    parameter int RAND_BITS       = 12,
    parameter int ROUNDS          = 4,
    parameter int TIMEOUT_TICKS   = 9999
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    output logic        led,
    output logic [3:0]  digit3,
    output logic [3:0]  digit2,
    output logic [3:0]  digit1,
    output logic [3:0]  digit0,
    output logic [3:0]  round_idx,
    output logic        result_valid,
    output logic        false_start,
    output logic [13:0] best_ticks,
    output logic [13:0] avg_ticks
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int PW       = $clog2(TICK_DIV);
    localparam int LOG2R    = $clog2(ROUNDS);
    localparam int SUM_W    = 14 + LOG2R;
    localparam int DW       = $clog2(MIN_DELAY_TICKS + (1 << RAND_BITS));

    // ---------------- button synchronisers and edge detect ----------------
    logic [1:0] sync1_q, sync2_q, prev_q, btn_p;
    logic       start_p, stop_p;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= {stop, start};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign btn_p   = sync2_q & ~prev_q;
    assign start_p = btn_p[0];
    assign stop_p  = btn_p[1];

    // ---------------- state and datapath registers ----------------
    state_t            state_q, state_d;
    logic [15:0]       lfsr_q;
    logic [PW-1:0]     presc_q, presc_d;
    logic [DW-1:0]     delay_q, delay_d;
    logic [13:0]       cnt_q, cnt_d;
    logic [15:0]       bcd_q, bcd_d;
    logic [3:0]        round_q, round_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [13:0]       best_q, best_d;
    logic [13:0]       avg_q, avg_d;
    logic              rv_q, rv_d;
    logic              fs_q, fs_d;

    logic              tick;
    logic [DW-1:0]     new_delay;
    logic              conv_start;
    logic              conv_done;
    logic [15:0]       conv_bcd;

    assign tick      = (presc_q == PW'(TICK_DIV - 1));
    assign new_delay = DW'(MIN_DELAY_TICKS) + DW'(lfsr_q[RAND_BITS-1:0]);

    always_comb begin
        state_d    = state_q;
        presc_d    = tick ? '0 : presc_q + PW'(1);
        delay_d    = delay_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        round_d    = round_q;
        sum_d      = sum_q;
        best_d     = best_q;
        avg_d      = avg_q;
        rv_d       = 1'b0;
        fs_d       = 1'b0;
        conv_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_p) begin
                    delay_d = new_delay;
                    round_d = '0;
                    sum_d   = '0;
                    best_d  = BEST_NONE;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // stop wins over a coincident tick, including the final one
                if (stop_p) begin
                    fs_d    = 1'b1;
                    state_d = FAULT;
                end else if (tick) begin
                    if (delay_q <= DW'(1)) begin
                        delay_d = '0;
                        cnt_d   = '0;
                        bcd_d   = '0;
                        state_d = REACT;
                    end else begin
                        delay_d = delay_q - DW'(1);
                    end
                end
            end
            REACT: begin
                if (stop_p || cnt_q == 14'(TIMEOUT_TICKS)) begin
                    rv_d    = 1'b1;
                    sum_d   = sum_q + SUM_W'(cnt_q);
                    best_d  = (cnt_q < best_q) ? cnt_q : best_q;
                    state_d = SHOW;
                end else if (tick) begin
                    cnt_d = cnt_q + 14'd1;
                    bcd_d = bcd_inc(bcd_q);
                end
            end
            SHOW: begin
                if (start_p) begin
                    if (round_q < 4'(ROUNDS - 1)) begin
                        round_d = round_q + 4'd1;
                        delay_d = new_delay;
                        state_d = WAIT;
                    end else begin
                        avg_d      = 14'(sum_q >> LOG2R);
                        conv_start = 1'b1;
                        state_d    = SUMMARY;
                    end
                end
            end
            FAULT: begin
                if (start_p) begin
                    delay_d = new_delay;
                    state_d = WAIT;
                end
            end
            SUMMARY: begin
                if (start_p) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Tick phase restarts on entry so the first tick is TICK_DIV clocks later.
        if ((state_d == WAIT || state_d == REACT) && state_d != state_q) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            presc_q <= '0;
            delay_q <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            round_q <= '0;
            sum_q   <= '0;
            best_q  <= BEST_NONE;
            avg_q   <= '0;
            rv_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_next(lfsr_q);
            presc_q <= presc_d;
            delay_q <= delay_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            round_q <= round_d;
            sum_q   <= sum_d;
            best_q  <= best_d;
            avg_q   <= avg_d;
            rv_q    <= rv_d;
            fs_q    <= fs_d;
        end
    end

    // Best value is already final when SHOW hands over to SUMMARY.
    bin2bcd_seq u_bin2bcd (
        .clk     (clock),
        .rst_n   (reset),
        .start_i (conv_start),
        .bin_i   (best_q),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    // ---------------- outputs ----------------
    logic [15:0] disp;

    always_comb begin
        disp = {4{GLYPH_DASH}};
        case (state_q)
            IDLE:    disp = {GLYPH_DASH, GLYPH_H, GLYPH_I, GLYPH_DASH};
            WAIT:    disp = {4{GLYPH_DASH}};
            REACT,
            SHOW:    disp = bcd_q;
            FAULT:   disp = {GLYPH_E, GLYPH_DASH, GLYPH_DASH, GLYPH_DASH};
            SUMMARY: disp = conv_done ? conv_bcd : {4{GLYPH_DASH}};
            default: disp = {4{GLYPH_DASH}};
        endcase
    end

    // Decoded straight from state so the lamp drops with an asynchronous reset.
    assign led          = (state_q == REACT);
    assign {digit3, digit2, digit1, digit0} = disp;
    assign round_idx    = round_q;
    assign result_valid = rv_q;
    assign false_start  = fs_q;
    assign best_ticks   = best_q;
    assign avg_ticks    = avg_q;

endmodule

// File: tb/tb_reaction_timer_multi.sv
// ----------------------------------------------------------------------------
// tb_reaction_timer_multi
// Directed + randomised sessions against a behavioural model: LFSR sequence,
// delay = MIN + lfsr[1:0] ticks, reaction = completed ticks before stop,
// best = min of results, avg = sum / ROUNDS.
// ----------------------------------------------------------------------------
module tb_reaction_timer_multi;

    localparam int TDIV   = 10;
    localparam int MIN_D  = 5;
    localparam int TOUT   = 120;
    localparam int NROUND = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic        led;
    logic [3:0]  digit3, digit2, digit1, digit0;
    logic [3:0]  round_idx;
    logic        result_valid, false_start;
    logic [13:0] best_ticks, avg_ticks;
    logic [15:0] disp;

    assign disp = {digit3, digit2, digit1, digit0};

    reaction_timer_multi #(
        .CLK_HZ          (1000),
        .TICK_HZ         (100),
        .MIN_DELAY_TICKS (MIN_D),
        .RAND_BITS       (2),
        .ROUNDS          (NROUND),
        .TIMEOUT_TICKS   (TOUT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .led          (led),
        .digit3       (digit3),
        .digit2       (digit2),
        .digit1       (digit1),
        .digit0       (digit0),
        .round_idx    (round_idx),
        .result_valid (result_valid),
        .false_start  (false_start),
        .best_ticks   (best_ticks),
        .avg_ticks    (avg_ticks)
    );

    always #5 clock = ~clock;

    // Reference LFSR: free-running sequence from the seed, reset with the DUT.
    logic [15:0] m_lfsr;
    always @(posedge clock or negedge reset) begin
        if (!reset) m_lfsr <= 16'h00FF;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    int nerr = 0;
    int nchk = 0;
    int results[$];

    function automatic logic [15:0] bcd_of(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int model_best();
        int b = 16383;
        foreach (results[i]) if (results[i] < b) b = results[i];
        return b;
    endfunction

    function automatic int model_avg();
        int s = 0;
        foreach (results[i]) s += results[i];
        return s / NROUND;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Press a button at the next falling edge; the FSM acts on the third
    // rising edge after that. Returns half a clock after the action edge,
    // with lf = the LFSR value the FSM sampled on that edge.
    task automatic press(input bit is_stop, output logic [15:0] lf);
        @(negedge clock);
        if (is_stop) stop = 1'b1; else start = 1'b1;
        @(negedge clock);
        @(negedge clock);
        lf = m_lfsr;
        @(negedge clock);
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Called just after WAIT entry: led must rise delay*TDIV clocks later.
    task automatic wait_led(input logic [15:0] lf, input string tag);
        int k   = 0;
        int exp = (MIN_D + int'(lf[1:0])) * TDIV;
        while (led !== 1'b1 && k < exp + 50) begin
            @(negedge clock);
            k++;
        end
        check(tag, k, exp);
    endtask

    // Called just after the lamp rises: stop is acted on k clocks later.
    task automatic react_stop(input int k, input string tag);
        logic [15:0] lf;
        int r;
        repeat (k - 4) @(negedge clock);
        press(1'b1, lf);
        r = (k - 1) / TDIV;   // ticks strictly before the stop edge
        if (r > TOUT) r = TOUT;
        results.push_back(r);
        check({tag, "_valid"}, result_valid, 1);
        check({tag, "_led"}, led, 0);
        check({tag, "_digits"}, disp, bcd_of(r));
        check({tag, "_best"}, best_ticks, model_best());
        @(negedge clock);
        check({tag, "_valid_end"}, result_valid, 0);
        $display("round result %0d ticks (stop %0d clocks after lamp)", r, k);
    endtask

    task automatic finish_session(input string tag);
        logic [15:0] lf;
        int k = 0;
        press(1'b0, lf);
        check({tag, "_avg"}, avg_ticks, model_avg());
        check({tag, "_dash"}, disp, 16'hCCCC);
        while (disp === 16'hCCCC && k < 40) begin
            @(negedge clock);
            k++;
        end
        check({tag, "_conv_time"}, (k <= 16), 1);
        check({tag, "_best_digits"}, disp, bcd_of(model_best()));
        check({tag, "_best"}, best_ticks, model_best());
        $display("summary avg=%0d best=%0d", model_avg(), model_best());
        press(1'b0, lf);
        check({tag, "_idle"}, disp, 16'hCABC);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [15:0] lf;
        int k;
        int rk;

        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_digits", disp, 16'hCABC);
        check("rst_led", led, 0);
        check("rst_best", best_ticks, 16383);
        check("rst_avg", avg_ticks, 0);
        check("rst_round", round_idx, 0);
        check("rst_pulses", {result_valid, false_start}, 0);

        // ---- session A: results 7 and 3 with a false start in round 1 ----
        results.delete();
        press(1'b0, lf);
        check("a_wait_digits", disp, 16'hCCCC);
        check("a_best_cleared", best_ticks, 16383);
        wait_led(lf, "a0_led_rise");
        check("a0_react_zero", disp, 16'h0000);
        react_stop(75, "a0");

        press(1'b0, lf);
        check("a1_round", round_idx, 1);
        repeat (10) @(negedge clock);
        press(1'b1, lf);
        check("a1_false_start", false_start, 1);
        check("a1_fault_digits", disp, 16'hDCCC);
        check("a1_fault_round", round_idx, 1);
        check("a1_fault_led", led, 0);
        @(negedge clock);
        check("a1_fs_end", false_start, 0);
        $display("false start in round 1");
        press(1'b0, lf);
        check("a1_rewait_digits", disp, 16'hCCCC);
        wait_led(lf, "a1_led_rise");
        react_stop(37, "a1");
        finish_session("a");

        // ---- session B: random reaction, then a timeout round ----
        results.delete();
        press(1'b0, lf);
        wait_led(lf, "b0_led_rise");
        rk = $urandom_range(4, 400);
        react_stop(rk, "b0");
        press(1'b0, lf);
        wait_led(lf, "b1_led_rise");
        k = 0;
        while (result_valid !== 1'b1 && k < TOUT * TDIV + 50) begin
            @(negedge clock);
            k++;
            if (k == 555) check("b1_live_count", disp, bcd_of(55));
        end
        check("b1_timeout_time", k, TOUT * TDIV + 1);
        check("b1_timeout_digits", disp, bcd_of(TOUT));
        check("b1_timeout_led", led, 0);
        results.push_back(TOUT);
        check("b1_best", best_ticks, model_best());
        $display("round result %0d ticks (timeout)", TOUT);
        finish_session("b");

        // ---- session C: reset in the middle of REACT ----
        press(1'b0, lf);
        wait_led(lf, "c0_led_rise");
        repeat (23) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("c_rst_led", led, 0);
        check("c_rst_digits", disp, 16'hCABC);
        check("c_rst_best", best_ticks, 16383);
        check("c_rst_avg", avg_ticks, 0);
        check("c_rst_round", round_idx, 0);
        $display("reset asserted mid-REACT");
        @(negedge clock);
        reset = 1'b1;

        results.delete();
        press(1'b0, lf);
        wait_led(lf, "d0_led_rise");
        react_stop($urandom_range(4, 300), "d0");
        press(1'b0, lf);
        wait_led(lf, "d1_led_rise");
        react_stop($urandom_range(4, 300), "d1");
        finish_session("d");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/reaction_timer_multi.md
Name: reaction_timer_multi

Overview:
Parametrised multi-round reaction timer, successor to the single-shot reaction timer.
- Runs ROUNDS trials, each with a random delay, then lights led and measures reaction time in ticks.
- Detects false starts, saturates on timeout, tracks best and average reaction time.
- Drives four BCD/glyph digits into the existing 7-segment muxer.

Parameters:
CLK_HZ, 100000000, input clock frequency
TICK_HZ, 1000, measurement resolution; TICK_DIV = CLK_HZ/TICK_HZ, must be an integer >= 2
MIN_DELAY_TICKS, 1000, fixed part of the pre-stimulus delay
RAND_BITS, 12, random delay part = lfsr[RAND_BITS-1:0] ticks (0..2^RAND_BITS-1)
ROUNDS, 4, trials per session; power of two, 2..16
TIMEOUT_TICKS, 9999, reaction count saturation (<= 9999)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  raw start button level
stop  in  1  raw stop button level
led  out  1  stimulus lamp
digit3..digit0  out  4 each  display codes: 0-9 BCD; 10=H, 11=I, 12=dash, 13=E
round_idx  out  4  current round, 0-based
result_valid  out  1  one-cycle pulse when a round result is latched
false_start  out  1  one-cycle pulse on early stop
best_ticks  out  14  best reaction of the session (16383 = none yet)
avg_ticks  out  14  sum of ROUNDS results >> log2(ROUNDS), valid in SUMMARY

Behaviour:
- Reset (reset=0, async): state IDLE, led=0, digits 12,10,11,12 ("-HI-"), round_idx=0, pulses 0, best_ticks=16383, avg_ticks=0, sum=0, LFSR=16'h00FF.
- Inputs: 2-FF synchroniser each, then rising-edge detect -> start_p / stop_p, 1 clock wide. Latency press->FSM action = 3 clocks.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; shifts every clock regardless of state; never all-zero.
- Prescaler: counts 0..TICK_DIV-1, tick on terminal count; cleared on every entry to WAIT or REACT, so the first tick lands exactly TICK_DIV clocks after entry.
- States:
  IDLE: show "-HI-". start_p -> delay = MIN_DELAY_TICKS + lfsr[RAND_BITS-1:0] sampled that cycle; round_idx=0; sum=0; best=16383 -> WAIT.
  WAIT: digits all 12. Decrement delay per tick. stop_p -> FAULT, false_start pulse. Delay reaching 0 -> REACT, led=1, BCD and binary reaction counters = 0.
  REACT: led=1. Each tick increments the 4-digit BCD counter (ripple 9->0) and the binary counter; digits show the live count. stop_p -> SHOW. Count == TIMEOUT_TICKS -> SHOW, value held at TIMEOUT_TICKS.
  SHOW entry (one cycle): led=0, latch result, result_valid pulse, sum += result, best = min(best, result). Show latched BCD. start_p -> round_idx<ROUNDS-1 ? (round_idx++, new delay, WAIT) : SUMMARY.
  FAULT: led=0, show 13,12,12,12 ("E---"). start_p -> new delay, same round_idx -> WAIT. Nothing accumulated.
  SUMMARY: avg_ticks = sum>>log2(ROUNDS); digits show best in BCD via the bcd converter. start_p -> IDLE.
- Simultaneous events: in WAIT/REACT stop_p wins over a coincident tick or start_p; in SHOW/FAULT/SUMMARY/IDLE stop_p is ignored.
- Delay becoming 0 and stop_p in the same cycle: false start.
- Width: sum is 14+log2(ROUNDS) bits, no overflow by construction; best compared in binary.
- Reset mid-operation: everything returns to reset values immediately; led drops asynchronously.

Decomposition:
- Package reaction_pkg: state enum (IDLE, WAIT, REACT, SHOW, FAULT, SUMMARY); glyph constants GLYPH_H=10, GLYPH_I=11, GLYPH_DASH=12, GLYPH_E=13; LFSR seed and tap mask.
- Sub-module bin2bcd_seq: iterative double-dabble, 14-bit binary -> 4 BCD digits, 14 cycles, start/done handshake; launched on SUMMARY entry; digits show dashes until done.

Test Plan (CLK_HZ=1000, TICK_HZ=100 -> TICK_DIV=10, MIN_DELAY_TICKS=5, RAND_BITS=2, ROUNDS=2):
- Reset release -> digits 12,10,11,12; led=0; best_ticks=16383; LFSR=16'h00FF.
- start press, no stop -> led rises after exactly (5+lfsr[1:0])*10 clocks from WAIT entry; stop after 37 clocks of led -> result_valid, digits 0,0,0,3, best_ticks=3.
- stop press during WAIT -> false_start pulse, digits 13,12,12,12, round_idx unchanged; next start re-enters WAIT.
- Never press stop in REACT -> SHOW at count 9999, digits 9,9,9,9, led=0.
- Two rounds with results 7 and 3, then start -> SUMMARY, avg_ticks=5, best_ticks=3, digits 0,0,0,3 within 16 clocks.
- Assert reset mid-REACT -> led=0 the same cycle, state IDLE, sum and best cleared.
